// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, status flags and an accumulator.
// Stage 1 registers operands; stage 2 computes and holds the result until the sink takes it.
module alu_pipe #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   res,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  typedef enum logic [3:0] {
    OpAdd  = 4'h0, OpSub  = 4'h1, OpAnd  = 4'h2, OpOr   = 4'h3,
    OpNotA = 4'h4, OpNotB = 4'h5, OpShrA = 4'h6, OpShlA = 4'h7,
    OpXor  = 4'h8, OpShrB = 4'h9, OpShlB = 4'hA, OpIncA = 4'hB,
    OpIncB = 4'hC, OpDecA = 4'hD, OpDecB = 4'hE, OpAcc  = 4'hF
  } op_e;

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  op_e              s1_op;

  logic             s2_valid;
  logic [WIDTH:0]   res_q;
  logic             z_q, n_q, v_q;
  logic [WIDTH-1:0] acc_q;

  logic             s1_adv, s2_adv;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OpAdd;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op_e'(op);
      end
    end
  end

  // Shared adder/subtractor: x/y pick the operands, the ACC base folds in a same-cycle clear.
  logic [WIDTH-1:0] acc_base, x, y;
  logic             do_sub, arith, alu_v;
  logic [WIDTH:0]   add_full, sub_full, alu_res;

  always_comb begin
    acc_base = acc_clr ? '0 : acc_q;
    x        = s1_a;
    y        = s1_b;
    do_sub   = 1'b0;
    arith    = 1'b0;
    case (s1_op)
      OpAdd:  arith = 1'b1;
      OpSub:  begin arith = 1'b1; do_sub = 1'b1; end
      OpIncA: begin arith = 1'b1; y = One; end
      OpIncB: begin arith = 1'b1; x = s1_b; y = One; end
      OpDecA: begin arith = 1'b1; do_sub = 1'b1; y = One; end
      OpDecB: begin arith = 1'b1; do_sub = 1'b1; x = s1_b; y = One; end
      OpAcc:  begin arith = 1'b1; x = acc_base; y = s1_a; end
      default: ;
    endcase

    add_full = {1'b0, x} + {1'b0, y};
    sub_full = {1'b0, x} - {1'b0, y};

    alu_v = 1'b0;
    if (arith) begin
      if (do_sub) alu_v = (x[WIDTH-1] != y[WIDTH-1]) && (sub_full[WIDTH-1] != x[WIDTH-1]);
      else        alu_v = (x[WIDTH-1] == y[WIDTH-1]) && (add_full[WIDTH-1] != x[WIDTH-1]);
    end

    alu_res = do_sub ? sub_full : add_full;
    case (s1_op)
      OpAnd:  alu_res = {1'b0, s1_a & s1_b};
      OpOr:   alu_res = {1'b0, s1_a | s1_b};
      OpXor:  alu_res = {1'b0, s1_a ^ s1_b};
      OpNotA: alu_res = {1'b0, ~s1_a};
      OpNotB: alu_res = {1'b0, ~s1_b};
      OpShrA: alu_res = {1'b0, s1_a >> 1};
      OpShlA: alu_res = {s1_a, 1'b0};
      OpShrB: alu_res = {1'b0, s1_b >> 1};
      OpShlB: alu_res = {s1_b, 1'b0};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      res_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        res_q <= alu_res;
        z_q   <= (alu_res[WIDTH-1:0] == '0);
        n_q   <= alu_res[WIDTH-1];
        v_q   <= alu_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (s1_adv && s1_op == OpAcc) begin
      acc_q <= add_full[WIDTH-1:0];
    end else if (acc_clr) begin
      acc_q <= '0;
    end
  end

  assign out_valid = s2_valid;
  assign res       = res_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_v    = v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: transaction-level reference model with a per-cycle compare process
// plus directed vectors pinned to hand-computed literals.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0, b = '0, op = '0;
  logic       acc_clr = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] res;
  logic       flag_z, flag_n, flag_v;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: {res, z, n, v} per accepted beat, using signed-range arithmetic.
  typedef struct packed {logic [4:0] r; logic z; logic n; logic v;} exp_t;
  exp_t q[$];
  exp_t log_q[$];
  int   model_acc = 0;
  logic beat_clr = 1'b0;

  function automatic int sv(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  function automatic exp_t compute(input int x, input int y, input int o, input bit clr);
    exp_t e;
    int   full, s, base;
    bit   v;
    v = 0;
    s = 0;
    case (o)
      0:  begin full = x + y; s = sv(x) + sv(y); v = 1; end
      1:  begin full = ((x < y) ? 16 : 0) + (x - y + 16) % 16; s = sv(x) - sv(y); v = 1; end
      2:  full = x & y;
      3:  full = x | y;
      4:  full = 15 - x;
      5:  full = 15 - y;
      6:  full = x / 2;
      7:  full = x * 2;
      8:  full = x ^ y;
      9:  full = y / 2;
      10: full = y * 2;
      11: begin full = x + 1; s = sv(x) + 1; v = 1; end
      12: begin full = y + 1; s = sv(y) + 1; v = 1; end
      13: begin full = ((x < 1) ? 16 : 0) + (x + 15) % 16; s = sv(x) - 1; v = 1; end
      14: begin full = ((y < 1) ? 16 : 0) + (y + 15) % 16; s = sv(y) - 1; v = 1; end
      default: begin
        base = clr ? 0 : model_acc;
        full = base + x;
        s = sv(base) + sv(x);
        v = 1;
        model_acc = full % 16;
      end
    endcase
    e.r = full[4:0];
    e.z = (full % 16) == 0;
    e.n = (full % 16) >= 8;
    e.v = v && (s < -8 || s > 7);
    return e;
  endfunction

  // Compare process: every negedge, outputs are stable and the coming edge's handshakes visible.
  logic [8:0] held_val;
  bit         held = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      q.delete();
      held = 0;
      model_acc = 0;
    end else begin
      check("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      if (q.size() == 0) check("idle_out_valid", out_valid, 0);
      if (held) check("stall_hold", {out_valid, res, flag_z, flag_n, flag_v}, held_val);
      held = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_result", 1, 0);
        end else begin
          check("result", {res, flag_z, flag_n, flag_v}, q.pop_front());
        end
        log_q.push_back({res, flag_z, flag_n, flag_v});
      end else if (out_valid) begin
        held = 1;
        held_val = {out_valid, res, flag_z, flag_n, flag_v};
      end
      if (in_valid && in_ready) q.push_back(compute(a, b, op, beat_clr));
    end
  end

  // out_ready pattern: 0 = held high, 1 = 1,0,0,1 repeating, 2 = held low.
  int or_mode = 0;
  initial begin
    int pat_i = 0;
    forever begin
      @(posedge clk);
      #1;
      pat_i++;
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
        default: out_ready = 1'b0;
      endcase
    end
  end

  bit clr_next = 0;

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc_clr  = clr_next;
      clr_next = 0;
    end
  endtask

  // Returns at the negedge where the beat is seen accepted; acc_clr follows one cycle later.
  task automatic send(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vo,
                      input bit vclr);
    bit ok = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = va;
    b = vb;
    op = vo;
    beat_clr = vclr;
    acc_clr = clr_next;
    clr_next = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else begin
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    clr_next = vclr;
  endtask

  task automatic drain();
    int k = 0;
    do begin
      drive_idle(1);
      k++;
    end while ((q.size() != 0 || out_valid) && k < 60);
    if (k >= 60) check("drain_timeout", 0, 1);
  endtask

  task automatic lit(input string name, input int idx, input logic [7:0] expv);
    if (idx < log_q.size()) check(name, log_q[idx], expv);
    else check(name, 32'hffff_ffff, expv);
  endtask

  int base;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, res, flag_z, flag_n, flag_v}, 0);
    rst_n = 1'b1;

    // ADD with carry and overflow, plus two-edge latency
    base = log_q.size();
    send(4'd9, 4'd8, 4'h0, 0);
    drive_idle(1);
    @(negedge clk);
    check("latency_edge1", out_valid, 0);
    @(negedge clk);
    check("latency_edge2", out_valid, 1);
    drain();
    lit("add_9_8", base, {5'h11, 1'b0, 1'b0, 1'b1});

    // SUB with borrow, SUB to zero
    base = log_q.size();
    send(4'd3, 4'd5, 4'h1, 0);
    send(4'd5, 4'd5, 4'h1, 0);
    drain();
    lit("sub_3_5", base, {5'h1E, 1'b0, 1'b1, 1'b0});
    lit("sub_5_5", base + 1, {5'h00, 1'b1, 1'b0, 1'b0});

    // NOT / SHL / INC wrap / DEC borrow / DEC overflow
    base = log_q.size();
    send(4'b1010, 4'd0, 4'h4, 0);
    send(4'b1001, 4'd0, 4'h7, 0);
    send(4'hF, 4'd0, 4'hB, 0);
    send(4'h0, 4'd0, 4'hD, 0);
    send(4'h8, 4'd0, 4'hD, 0);
    drain();
    lit("not_a", base, {5'b00101, 1'b0, 1'b0, 1'b0});
    lit("shl_a", base + 1, {5'b10010, 1'b0, 1'b0, 1'b0});
    lit("inc_wrap", base + 2, {5'h10, 1'b1, 1'b0, 1'b0});
    lit("dec_borrow", base + 3, {5'h1F, 1'b0, 1'b1, 1'b0});
    lit("dec_ovf", base + 4, {5'h07, 1'b0, 1'b0, 1'b1});

    // Sweep of non-accumulator opcodes against the model
    for (int i = 0; i < 15; i++) send(4'((i * 7) % 16), 4'((i * 5 + 3) % 16), 4'(i), 0);
    drain();

    // Streaming under a toggling sink
    base = log_q.size();
    or_mode = 1;
    for (int i = 0; i < 8; i++) send(4'((i * 3) % 16), 4'(i + 5), 4'((i % 2) ? 1 : 0), 0);
    drain();
    or_mode = 0;
    drive_idle(2);
    check("stream_count", log_q.size() - base, 8);

    // Standalone accumulator clear, then chained ACC beats and a coincident clear
    send(4'd6, 4'd0, 4'hF, 0);
    drain();
    @(posedge clk);
    #1;
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    model_acc = 0;
    base = log_q.size();
    send(4'd3, 4'd0, 4'hF, 0);
    send(4'd5, 4'd0, 4'hF, 0);
    send(4'd9, 4'd0, 4'hF, 0);
    send(4'd2, 4'd0, 4'hF, 1);
    drain();
    lit("acc_3", base, {5'h03, 1'b0, 1'b0, 1'b0});
    lit("acc_8", base + 1, {5'h08, 1'b0, 1'b1, 1'b1});
    lit("acc_11", base + 2, {5'h11, 1'b0, 1'b0, 1'b1});
    lit("acc_clr_2", base + 3, {5'h02, 1'b0, 1'b0, 1'b0});

    // Reset with two beats stuck in the pipeline
    or_mode = 2;
    drive_idle(1);
    send(4'd5, 4'd0, 4'hF, 0);
    send(4'd1, 4'd1, 4'h0, 0);
    @(posedge clk);
    #2;
    check("pre_reset_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("reset_async_valid", out_valid, 0);
    or_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = log_q.size();
    send(4'd2, 4'd0, 4'hF, 0);
    drive_idle(1);
    @(negedge clk);
    check("post_reset_edge1", out_valid, 0);
    @(negedge clk);
    check("post_reset_edge2", out_valid, 1);
    drain();
    lit("post_reset_acc", base, {5'h02, 1'b0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d mismatched so far", n_bad);
    $fatal(1);
  end

endmodule
